sa_operand_loader: RTL and testbench
====================================

Name: sa_operand_loader

Overview:
- Upstream feeder for the 12x12 systolic matrix multiplier.
- Accepts a serial stream of DWIDTH-bit IEEE-754 doubles over a valid/ready handshake and assembles two NxN operand buffers: A row-major, then B row-major.
- Presents both buffers to the multiplier, together with the column-enable mask latched at start.
- Holds load_en high until the multiplier reports cal_finish, then releases load_en so the multiplier's edge-detected start re-arms.
- Supports reusing the previously loaded B matrix, e.g. for Kalman F/F^T passes.

Parameters:
DWIDTH  64  element width (IEEE-754 double)
N       12  matrix dimension; buffers are NxN, stream length is N*N per matrix

Ports:
clk        in   1                 clock
rst        in   1                 synchronous active-high reset
start      in   1                 begin a load/run transaction; sampled only in IDLE
keep_b     in   1                 sampled with start; 1 = skip B load and reuse current b_col contents
enb_1_in   in   1                 column-0 enable, latched at start
enb_2_6_in in   1                 columns 1..5 enable, latched at start
enb_7_12_in in  1                 columns 6..11 enable, latched at start
in_valid   in   1                 stream element valid
in_data    in   DWIDTH            stream element
in_ready   out  1                 loader accepts element this cycle
a_row      out  DWIDTH x N x N    operand A, a_row[i][k]
b_col      out  DWIDTH x N x N    operand B, b_col[k][j]
enb_1      out  1                 latched enable to multiplier
enb_2_6    out  1                 latched enable to multiplier
enb_7_12   out  1                 latched enable to multiplier
load_en    out  1                 run request to multiplier (level)
cal_finish in   1                 multiplier completion (level, high until load_en drops)
busy       out  1                 state != IDLE
done       out  1                 one-cycle pulse: transaction complete

Behaviour:
- Reset, synchronous, rst=1 at a clk edge:
  - state=IDLE.
  - All a_row/b_col entries = 0.
  - load_en, done, in_ready, busy, all enb outputs = 0.
  - Row/column counters = 0.
  - Reset during any state, including RUN, takes effect the same edge; load_en is low from the next cycle.
- States: IDLE, LOAD_A, LOAD_B, RUN, RELEASE.
- IDLE:
  - start=1 -> latch enb_*_in into enb_* and latch keep_b; clear counters; go to LOAD_A.
  - start in any other state is ignored.
- LOAD_A:
  - in_ready=1 (registered, high for the whole state).
  - Accept when in_valid & in_ready. The element writes a_row[r][c], where r/c are the row/column counters.
  - Counters: c increments; wraps to 0 at N-1 with r incrementing.
  - Accepting element (N-1,N-1) -> counters clear. Next state is LOAD_B if keep_b=0, else RUN.
  - in_valid gaps stall the counters; there is no timeout.
- LOAD_B: same as LOAD_A, writing b_col[r][c]. Last element -> RUN.
- The cycle after the last accepted element, in_ready=0. Buffers are never written outside LOAD_A/LOAD_B.
- RUN:
  - load_en=1, asserted the first cycle in RUN, i.e. the cycle after the final accepted element.
  - Stay until cal_finish=1 is sampled, then go to RELEASE.
  - cal_finish sampled in any other state is ignored.
- RELEASE:
  - load_en=0 and done=1 for exactly this one cycle; then IDLE.
  - load_en is therefore low for at least 2 cycles (RELEASE + first IDLE) before any new RUN, so the multiplier's rising-edge start detect is guaranteed.
- Outputs a_row/b_col/enb_* stay stable from entry to RUN through RELEASE and IDLE, until the next start. With keep_b=1, b_col keeps its last contents (0 after reset).
- busy=1 in LOAD_A, LOAD_B, RUN and RELEASE.
- No arithmetic on data; elements pass bit-exact.
- Counter width is $clog2(N) per index.

Test Plan:
- Basic load, keep_b=0, enables 1/1/1:
  - Stimulus: stream 288 elements continuously, value = 64'(index), then hold cal_finish high 10 cycles after load_en rises.
  - Required: a_row[i][k] = 12*i+k; b_col[k][j] = 144+12*k+j.
  - Required: load_en rises the cycle after element 287 is accepted; done pulses once, with load_en falling in the same cycle.
- Backpressure/gaps: toggle in_valid randomly at 50%. Required: same buffer contents as the basic test, in_ready high throughout LOAD_A/LOAD_B, and no element skipped or duplicated.
- keep_b reuse:
  - Stimulus: after the basic test, start with keep_b=1 and stream 144 elements of value 0xFF.
  - Required: a_row is all 0xFF, b_col is unchanged, and load_en rises after element 143.
- Start while busy: pulse start during LOAD_B and during RUN. Required: no effect, counters continue, and the enb latches are unchanged.
- Reset mid-operation:
  - Stimulus: assert rst after 70 A elements; later assert rst in RUN.
  - Required: next cycle state=IDLE, load_en=0, in_ready=0, all buffers 0, and no done pulse.
- Enable latching: start with enb=1/0/1, then change the inputs during RUN. Required: enb_1=1, enb_2_6=0, enb_7_12=1 held until the next start.

Source files
------------

// File: rtl/sa_operand_loader.sv
// Operand loader for the 12x12 systolic multiplier: assembles A and B from a
// serial element stream, then holds load_en until the multiplier finishes.
module sa_operand_loader #(
    parameter int DWIDTH = 64,
    parameter int N      = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             keep_b,
    input  logic                             enb_1_in,
    input  logic                             enb_2_6_in,
    input  logic                             enb_7_12_in,
    input  logic                             in_valid,
    input  logic [DWIDTH-1:0]                in_data,
    output logic                             in_ready,
    output logic [N-1:0][N-1:0][DWIDTH-1:0]  a_row,
    output logic [N-1:0][N-1:0][DWIDTH-1:0]  b_col,
    output logic                             enb_1,
    output logic                             enb_2_6,
    output logic                             enb_7_12,
    output logic                             load_en,
    input  logic                             cal_finish,
    output logic                             busy,
    output logic                             done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        RUN     = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t                            state_q, state_d;
    logic [CW-1:0]                     r_q, r_d, c_q, c_d;
    logic                              keep_b_q, keep_b_d;
    logic [2:0]                        enb_q, enb_d;
    logic                              in_ready_q, load_en_q, done_q, busy_q;
    logic [N-1:0][N-1:0][DWIDTH-1:0]   a_q, b_q;
    logic                              accept, last_elem;

    assign accept    = in_valid & in_ready_q;
    assign last_elem = (r_q == LAST) && (c_q == LAST);

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        c_d      = c_q;
        keep_b_d = keep_b_q;
        enb_d    = enb_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    enb_d    = {enb_1_in, enb_2_6_in, enb_7_12_in};
                    keep_b_d = keep_b;
                    r_d      = '0;
                    c_d      = '0;
                    state_d  = LOAD_A;
                end
            end
            LOAD_A, LOAD_B: begin
                if (accept) begin
                    if (last_elem) begin
                        r_d     = '0;
                        c_d     = '0;
                        state_d = (state_q == LOAD_A && !keep_b_q) ? LOAD_B : RUN;
                    end else if (c_q == LAST) begin
                        c_d = '0;
                        r_d = r_q + 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (cal_finish) state_d = RELEASE;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake/status flags are registered from the next state so they line
    // up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            r_q        <= '0;
            c_q        <= '0;
            keep_b_q   <= 1'b0;
            enb_q      <= '0;
            in_ready_q <= 1'b0;
            load_en_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            keep_b_q   <= keep_b_d;
            enb_q      <= enb_d;
            in_ready_q <= (state_d == LOAD_A) || (state_d == LOAD_B);
            load_en_q  <= (state_d == RUN);
            done_q     <= (state_d == RELEASE);
            busy_q     <= (state_d != IDLE);
            if (accept && state_q == LOAD_A) a_q[r_q][c_q] <= in_data;
            if (accept && state_q == LOAD_B) b_q[r_q][c_q] <= in_data;
        end
    end

    assign in_ready = in_ready_q;
    assign a_row    = a_q;
    assign b_col    = b_q;
    assign enb_1    = enb_q[2];
    assign enb_2_6  = enb_q[1];
    assign enb_7_12 = enb_q[0];
    assign load_en  = load_en_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sa_operand_loader.sv
// Scoreboard bench for sa_operand_loader: stimulus queues expected operand
// sets, a monitor checks them when load_en rises and checks each done pulse.
module tb_sa_operand_loader;

    typedef logic [11:0][11:0][63:0] mat_t;
    typedef struct {
        mat_t       a;
        mat_t       b;
        logic [2:0] enb;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, keep_b, enb_1_in, enb_2_6_in, enb_7_12_in, in_valid, cal_finish;
    logic [63:0] in_data;
    logic in_ready, enb_1, enb_2_6, enb_7_12, load_en, busy, done;
    mat_t a_row, b_col;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_acc = 0;
    int done_exp = 0;
    exp_t exp_q[$];

    sa_operand_loader #(.DWIDTH(64), .N(12)) dut (
        .clk(clk), .rst(rst), .start(start), .keep_b(keep_b),
        .enb_1_in(enb_1_in), .enb_2_6_in(enb_2_6_in), .enb_7_12_in(enb_7_12_in),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .a_row(a_row), .b_col(b_col),
        .enb_1(enb_1), .enb_2_6(enb_2_6), .enb_7_12(enb_7_12),
        .load_en(load_en), .cal_finish(cal_finish), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event required none", name);
    endtask

    task automatic chk_mat(input string name, input mat_t act, input mat_t expv);
        bit reported = 0;
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            for (int i = 0; i < 12; i++)
                for (int j = 0; j < 12; j++)
                    if (!reported && act[i][j] !== expv[i][j]) begin
                        reported = 1;
                        $display("FAIL %s[%0d][%0d]: got %0h required %0h",
                                 name, i, j, act[i][j], expv[i][j]);
                    end
        end
    endtask

    function automatic mat_t seq_mat(input int base);
        mat_t m;
        for (int i = 0; i < 12; i++)
            for (int k = 0; k < 12; k++)
                m[i][k] = 64'(base + 12 * i + k);
        return m;
    endfunction

    function automatic mat_t const_mat(input logic [63:0] v);
        mat_t m;
        for (int i = 0; i < 12; i++)
            for (int k = 0; k < 12; k++)
                m[i][k] = v;
        return m;
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_load_en"}, 64'(load_en), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_enb"}, 64'({enb_1, enb_2_6, enb_7_12}), 64'd0);
        chk_mat({tag, "_a_row"}, a_row, '0);
        chk_mat({tag, "_b_col"}, b_col, '0);
    endtask

    // Monitor: checks operands at every load_en rise and every done pulse.
    initial begin
        logic le_prev;
        exp_t e;
        le_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (load_en && !le_prev) begin
                if (exp_q.size() == 0) fail_now("unexpected_run");
                else begin
                    e = exp_q.pop_front();
                    chk_mat("a_row", a_row, e.a);
                    chk_mat("b_col", b_col, e.b);
                    chk("enb_latched", 64'({enb_1, enb_2_6, enb_7_12}), 64'(e.enb));
                    chk("load_en_rise_cycle", 64'(cyc), 64'(last_acc));
                end
            end
            if (done) begin
                chk("done_load_en_low", 64'(load_en), 64'd0);
                chk("done_after_run", 64'(le_prev), 64'd1);
                if (done_exp == 0) fail_now("unexpected_done");
                else done_exp--;
            end
            le_prev = load_en;
        end
    end

    task automatic stream(input int n, input bit use_const, input logic [63:0] cval,
                          input int gap_pct, input int pulse_at, input bit full);
        int idx = 0;
        int stall = 0;
        bit rdy_ok = 1;
        while (idx < n && stall < 50) begin
            @(negedge clk);
            start = (idx == pulse_at);
            if (!in_ready) begin
                rdy_ok = 0;
                stall++;
            end else stall = 0;
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = use_const ? cval : 64'(idx);
            if (in_valid && in_ready) begin
                idx++;
                last_acc = cyc + 1;
            end
        end
        chk("in_ready_during_load", 64'(rdy_ok), 64'd1);
        if (full) begin
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
            chk("in_ready_after_last", 64'(in_ready), 64'd0);
        end
    endtask

    task automatic begin_txn(input bit kb, input logic [2:0] enb);
        @(negedge clk);
        start = 1'b1;
        keep_b = kb;
        {enb_1_in, enb_2_6_in, enb_7_12_in} = enb;
        @(negedge clk);
        start = 1'b0;
        keep_b = ~kb;
        {enb_1_in, enb_2_6_in, enb_7_12_in} = ~enb;
    endtask

    task automatic run_txn(input bit kb, input logic [2:0] enb, input int n,
                           input bit use_const, input logic [63:0] cval, input int gap,
                           input int pulse_at, input bit pulse_run, input bit finish);
        int t;
        begin_txn(kb, enb);
        stream(n, use_const, cval, gap, pulse_at, 1'b1);
        t = 0;
        while (!load_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!load_en) begin
            fail_now("load_en_timeout");
            return;
        end
        chk("busy_in_run", 64'(busy), 64'd1);
        if (pulse_run) begin
            @(negedge clk);
            start = 1'b1;
            {enb_1_in, enb_2_6_in, enb_7_12_in} = 3'b010;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("run_ignores_start", 64'({load_en, in_ready}), 64'b10);
        end
        if (!finish) return;
        repeat (10) @(negedge clk);
        done_exp++;
        cal_finish = 1'b1;
        t = 0;
        while (load_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (load_en) fail_now("load_en_release_timeout");
        cal_finish = 1'b0;
        @(negedge clk);
        chk("idle_not_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; keep_b = 1'b0; in_valid = 1'b0; in_data = '0;
        cal_finish = 1'b0; enb_1_in = 1'b0; enb_2_6_in = 1'b0; enb_7_12_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        // Basic load, continuous stream
        exp_q.push_back('{a: seq_mat(0), b: seq_mat(144), enb: 3'b111});
        run_txn(1'b0, 3'b111, 288, 1'b0, 64'd0, 0, -1, 1'b0, 1'b1);

        // Reuse B, A = 0xFF
        exp_q.push_back('{a: const_mat(64'hFF), b: seq_mat(144), enb: 3'b011});
        run_txn(1'b1, 3'b011, 144, 1'b1, 64'hFF, 0, -1, 1'b0, 1'b1);

        // 50% gaps, start pulses in LOAD_B and RUN, enables 1/0/1
        exp_q.push_back('{a: seq_mat(0), b: seq_mat(144), enb: 3'b101});
        run_txn(1'b0, 3'b101, 288, 1'b0, 64'd0, 50, 200, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        chk("enb_held_in_idle", 64'({enb_1, enb_2_6, enb_7_12}), 64'b101);
        chk_mat("a_row_held_in_idle", a_row, seq_mat(0));

        // Reset after 70 A elements
        begin_txn(1'b0, 3'b111);
        stream(70, 1'b0, 64'd0, 0, -1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("rst_load_a");

        // Reset in RUN: B reused after reset is all zero
        exp_q.push_back('{a: const_mat(64'h55), b: '0, enb: 3'b100});
        run_txn(1'b1, 3'b100, 144, 1'b1, 64'h55, 0, -1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("rst_run");
        repeat (5) @(negedge clk);
        chk("no_done_after_reset", 64'(done_exp), 64'd0);
        chk("all_runs_seen", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
